// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling, 2-of-3 majority voting per bit,
// optional parity, and a single-entry output holding register with overrun detection.
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       os_tick,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       HAS_PAR  = (PARITY_EN != 0);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic       sync1_q, sync1_d;
  logic       rxs_q, rxs_d;
  logic [2:0] state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       s7_q, s7_d;
  logic       s8_q, s8_d;
  logic       par_bad_q, par_bad_d;
  logic       load_pend_q, load_pend_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       maj;

  // Majority uses the live synchronized sample as the third vote at index 9.
  assign maj = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

  always_comb begin
    sync1_d       = rx_in;
    rxs_d         = sync1_q;
    state_d       = state_q;
    tick_d        = tick_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    s7_d          = s7_q;
    s8_d          = s8_q;
    par_bad_d     = par_bad_q;
    load_pend_d   = 1'b0;
    pend_data_d   = pend_data_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (os_tick && !rxs_q) begin
          state_d   = S_START;
          tick_d    = 4'd1;
          bit_idx_d = 3'd0;
          shift_d   = 8'h00;
          par_bad_d = 1'b0;
        end
      end
      S_WAIT_IDLE: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        if (os_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd7) s7_d = rxs_q;
          if (tick_q == 4'd8) s8_d = rxs_q;
          case (state_q)
            S_START: begin
              if (tick_q == 4'd9 && maj) begin
                state_d = S_IDLE;
                tick_d  = 4'd0;
              end else if (tick_q == 4'd15) begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              if (tick_q == 4'd9) shift_d[bit_idx_q] = maj;
              if (tick_q == 4'd15) begin
                if (bit_idx_q == LAST_BIT) state_d = HAS_PAR ? S_PARITY : S_STOP;
                else bit_idx_d = bit_idx_q + 3'd1;
              end
            end
            S_PARITY: begin
              if (tick_q == 4'd9) par_bad_d = maj ^ (^shift_q) ^ ODD;
              if (tick_q == 4'd15) state_d = S_STOP;
            end
            S_STOP: begin
              // Decide early at index 9 so a following start edge is not missed.
              if (tick_q == 4'd9) begin
                tick_d = 4'd0;
                if (!maj) begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_IDLE;
                end else if (par_bad_q) begin
                  parity_err_d = 1'b1;
                  state_d      = S_IDLE;
                end else begin
                  load_pend_d = 1'b1;
                  pend_data_d = shift_q;
                  state_d     = S_IDLE;
                end
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    if (load_pend_q) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_err_d = 1'b1;
      end else begin
        rx_data_d  = pend_data_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= S_IDLE;
      tick_q        <= 4'd0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      s7_q          <= 1'b1;
      s8_q          <= 1'b1;
      par_bad_q     <= 1'b0;
      load_pend_q   <= 1'b0;
      pend_data_q   <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rxs_q         <= rxs_d;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      s7_q          <= s7_d;
      s8_q          <= s8_d;
      par_bad_q     <= par_bad_d;
      load_pend_q   <= load_pend_d;
      pend_data_q   <= pend_data_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: one 8N1 instance and one 8E1 instance,
// os_tick every 4 clocks, line driven bit-aligned to the tick stream.
`timescale 1ns/1ps
module tb_uart_rx_os16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_tick = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b, fe_a, fe_b, pe_a, pe_b, oe_a, oe_b, busy_a, busy_b;
  int         checks = 0, errors = 0;
  int         fe_a_n = 0, pe_b_n = 0, oe_a_n = 0, pe_a_n = 0;
  bit         sel = 1'b0;

  uart_rx_os16 u_dut (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(rx_a), .rx_ready(rdy_a),
    .rx_data(data_a), .rx_valid(vld_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun_err(oe_a), .rx_busy(busy_a)
  );

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(rx_b), .rx_ready(rdy_b),
    .rx_data(data_b), .rx_valid(vld_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun_err(oe_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      os_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  always @(posedge clk) begin
    if (fe_a) fe_a_n <= fe_a_n + 1;
    if (pe_a) pe_a_n <= pe_a_n + 1;
    if (oe_a) oe_a_n <= oe_a_n + 1;
    if (pe_b) pe_b_n <= pe_b_n + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic set_line(input logic v);
    @(negedge clk);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send_head(input logic [7:0] d, input bit par, input logic pbit, input bit align);
    if (align) wait_ticks(1);
    set_line(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_line(d[i]);
      wait_ticks(16);
    end
    if (par) begin
      set_line(pbit);
      wait_ticks(16);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vld_a !== 1'b0 || data_a !== 8'h00) begin
      errors++; $display("FAIL reset_out: vld=%b data=%h, want 0/00", vld_a, data_a);
    end
    checks++;
    if (busy_a !== 1'b0 || fe_a !== 1'b0 || pe_a !== 1'b0 || oe_a !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b fe=%b pe=%b oe=%b, want 0", busy_a, fe_a, pe_a, oe_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    sel = 1'b0;
    send_head(8'hA5, 1'b0, 1'b0, 1'b1);
    set_line(1'b1);
    wait_ticks(10);
    #1;
    checks++;
    if (vld_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_decision: vld=%b busy=%b, want 0/0", vld_a, busy_a);
    end
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b1 || data_a !== 8'hA5) begin
      errors++; $display("FAIL basic_load: vld=%b data=%h, want 1/a5", vld_a, data_a);
    end
    rdy_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b0) begin
      errors++; $display("FAIL basic_consume: vld=%b, want 0", vld_a);
    end
    rdy_a = 1'b0;
    wait_ticks(6);
  endtask

  task automatic test_glitch();
    int f0, p0;
    f0 = fe_a_n; p0 = pe_a_n;
    sel = 1'b0;
    wait_ticks(1);
    set_line(1'b0);
    wait_ticks(1);
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL glitch_start: busy=%b, want 1", busy_a);
    end
    wait_ticks(3);
    set_line(1'b1);
    wait_ticks(6);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL glitch_idle: busy=%b at index 9, want 0", busy_a);
    end
    wait_ticks(20);
    #1;
    checks++;
    if (vld_a !== 1'b0 || busy_a !== 1'b0 || fe_a_n != f0 || pe_a_n != p0) begin
      errors++; $display("FAIL glitch_quiet: vld=%b busy=%b fe_n=%0d pe_n=%0d, want 0 0 %0d %0d",
                         vld_a, busy_a, fe_a_n, pe_a_n, f0, p0);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_a_n;
    sel = 1'b0;
    send_head(8'h3C, 1'b0, 1'b0, 1'b1);
    set_line(1'b0);
    wait_ticks(10);
    #1;
    checks++;
    if (fe_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL ferr_pulse: fe=%b busy=%b, want 1/1", fe_a, busy_a);
    end
    @(posedge clk); #1;
    checks++;
    if (fe_a !== 1'b0) begin
      errors++; $display("FAIL ferr_width: fe=%b one clk later, want 0", fe_a);
    end
    wait_ticks(16);
    #1;
    checks++;
    if (busy_a !== 1'b1 || vld_a !== 1'b0) begin
      errors++; $display("FAIL ferr_wait: busy=%b vld=%b with line low, want 1/0", busy_a, vld_a);
    end
    set_line(1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || fe_a_n != f0 + 1) begin
      errors++; $display("FAIL ferr_release: busy=%b fe_count=%0d, want 0/%0d", busy_a, fe_a_n - f0, 1);
    end
  endtask

  task automatic test_parity();
    int p0;
    p0 = pe_b_n;
    sel = 1'b1;
    send_head(8'h07, 1'b1, 1'b0, 1'b1);
    set_line(1'b1);
    wait_ticks(10);
    #1;
    checks++;
    if (pe_b !== 1'b1) begin
      errors++; $display("FAIL par_bad_pulse: pe=%b, want 1", pe_b);
    end
    @(posedge clk); #1;
    checks++;
    if (vld_b !== 1'b0 || pe_b_n != p0 + 1) begin
      errors++; $display("FAIL par_bad_drop: vld=%b pe_count=%0d, want 0/1", vld_b, pe_b_n - p0);
    end
    wait_ticks(6);
    send_head(8'h07, 1'b1, 1'b1, 1'b1);
    set_line(1'b1);
    wait_ticks(10);
    @(posedge clk); #1;
    checks++;
    if (vld_b !== 1'b1 || data_b !== 8'h07 || pe_b_n != p0 + 1) begin
      errors++; $display("FAIL par_good: vld=%b data=%h pe_count=%0d, want 1/07/1", vld_b, data_b, pe_b_n - p0);
    end
    rdy_b = 1'b1;
    @(posedge clk);
    rdy_b = 1'b0;
    wait_ticks(6);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = oe_a_n;
    sel = 1'b0;
    rdy_a = 1'b0;
    send_head(8'h11, 1'b0, 1'b0, 1'b1);
    set_line(1'b1);
    wait_ticks(10);
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b1 || data_a !== 8'h11) begin
      errors++; $display("FAIL b2b_first: vld=%b data=%h, want 1/11", vld_a, data_a);
    end
    wait_ticks(6);
    send_head(8'h22, 1'b0, 1'b0, 1'b0);
    set_line(1'b1);
    wait_ticks(10);
    @(posedge clk); #1;
    checks++;
    if (oe_a !== 1'b1 || vld_a !== 1'b1 || data_a !== 8'h11) begin
      errors++; $display("FAIL b2b_overrun: oe=%b vld=%b data=%h, want 1/1/11", oe_a, vld_a, data_a);
    end
    wait_ticks(6);
    send_head(8'h22, 1'b0, 1'b0, 1'b0);
    set_line(1'b1);
    wait_ticks(10);
    #1;
    rdy_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (oe_a !== 1'b0 || vld_a !== 1'b1 || data_a !== 8'h22) begin
      errors++; $display("FAIL b2b_replace: oe=%b vld=%b data=%h, want 0/1/22", oe_a, vld_a, data_a);
    end
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b0 || oe_a_n != o0 + 1) begin
      errors++; $display("FAIL b2b_clear: vld=%b oe_count=%0d, want 0/1", vld_a, oe_a_n - o0);
    end
    rdy_a = 1'b0;
    wait_ticks(6);
  endtask

  task automatic test_reset_mid();
    int f0, p0, o0;
    f0 = fe_a_n; p0 = pe_a_n; o0 = oe_a_n;
    sel = 1'b0;
    wait_ticks(1);
    set_line(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_line(1'b1);
      wait_ticks(16);
    end
    set_line(1'b1);
    wait_ticks(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: busy=%b vld=%b, want 0/0", busy_a, vld_a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(40);
    #1;
    checks++;
    if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: busy=%b vld=%b, want 0/0", busy_a, vld_a);
    end
    send_head(8'h5A, 1'b0, 1'b0, 1'b1);
    set_line(1'b1);
    wait_ticks(10);
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b1 || data_a !== 8'h5A) begin
      errors++; $display("FAIL rstmid_next: vld=%b data=%h, want 1/5a", vld_a, data_a);
    end
    checks++;
    if (fe_a_n != f0 || pe_a_n != p0 || oe_a_n != o0) begin
      errors++; $display("FAIL rstmid_flags: fe=%0d pe=%0d oe=%0d new pulses, want 0",
                         fe_a_n - f0, pe_a_n - p0, oe_a_n - o0);
    end
    rdy_a = 1'b1;
    @(posedge clk);
    rdy_a = 1'b0;
    wait_ticks(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter PARITY_EN, default 0: 1 means one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 os_tick  input  1  one-clk strobe at 16x baud rate.
REQ-007 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-008 rx_ready  input  1  consumer accepts the held byte.
REQ-009 rx_data  output  8  received byte, LSB-aligned, unused upper bits 0.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-011 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 parity_err  output  1  one-clk pulse: parity mismatch.
REQ-013 overrun_err  output  1  one-clk pulse: good byte dropped because the held byte was not consumed.
REQ-014 rx_busy  output  1  high in every state except IDLE.

Function
REQ-015 rx_in SHALL pass through a 2-flop synchronizer reset to 1; all logic uses the synchronized value rxs.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; a 4-bit tick index counts 0..15 within each bit, advancing only on os_tick.
REQ-017 IDLE: the first os_tick with rxs=0 SHALL be tick index 0 of the start bit, with transition to START.
REQ-018 Each bit SHALL be sampled on tick indices 7, 8 and 9, and the bit value SHALL be the majority (2 of 3) of those samples.
REQ-019 START: a majority of 1 at index 9 SHALL be a false start and return the FSM to IDLE with no flags; a majority of 0 SHALL continue to index 15, then DATA.
REQ-020 DATA: DATA_BITS bits SHALL be received LSB first, each spanning 16 ticks, then PARITY if PARITY_EN=1, else STOP.
REQ-021 PARITY: the decided bit SHALL be compared against the XOR of the data bits (inverted if PARITY_ODD); the result is recorded and the FSM goes to STOP after index 15.
REQ-022 STOP: the decision SHALL be made at index 9, with no wait for index 15, which allows back-to-back frames.
REQ-023 Stop=0: frame_err SHALL pulse, the byte SHALL be discarded, and the FSM SHALL go to WAIT_IDLE; WAIT_IDLE returns to IDLE on the first clk with rxs=1.
REQ-024 Stop=1 with parity mismatch: parity_err SHALL pulse, the byte SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-025 Frame error takes priority: only frame_err SHALL pulse when both the stop bit and the parity fail.
REQ-026 Good frame: on the clk after the stop decision, rx_data SHALL load and rx_valid SHALL set, unless the overrun case applies.
REQ-027 Overrun case: if rx_valid=1 and rx_ready=0 on the load cycle, overrun_err SHALL pulse and the old rx_data/rx_valid SHALL be kept.
REQ-028 If rx_ready=1 on the load cycle, the new byte SHALL replace the old one and no overrun is flagged.
REQ-029 rx_valid SHALL clear on the clk after rx_valid=1 and rx_ready=1, except as given in REQ-028; rx_data SHALL stay stable while rx_valid=1.
REQ-030 os_tick SHALL be ignored in IDLE while rxs=1, and clk cycles without os_tick SHALL leave the FSM and tick index unchanged.

Reset
REQ-031 While rst_n=0, regardless of clk or os_tick: FSM=IDLE, tick index=0, shift register=0, rx_data=0x00, rx_valid=0, all error pulses 0, rx_busy=0, synchronizer=1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no flag; after release the FSM SHALL wait for a fresh falling edge.

Verification
REQ-033 8N1, 16 ticks/bit, send 0xA5 -> rx_valid=1 and rx_data=0xA5 one clk after the stop index-9 tick; rx_ready=1 clears rx_valid the next clk.
REQ-034 Low glitch of 4 ticks on an idle line -> no rx_valid and no flags; FSM back in IDLE by start index 10.
REQ-035 Send 0x3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0, FSM stays in WAIT_IDLE until the line is high.
REQ-036 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulses, no rx_valid; with parity bit 1 -> rx_data=0x07.
REQ-037 Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11 held and overrun_err pulses at the second stop; repeat with rx_ready=1 on the second load cycle -> rx_data=0x22 and no overrun.
REQ-038 Assert rst_n=0 during data bit 4 of 0xFF, release, then send 0x5A -> only rx_data=0x5A is delivered.
